uarc_receiver_arbiter: RTL and testbench
========================================

# uarc_receiver_arbiter

Receiver-side front end for a core's UARC bus set. It takes `TOTAL_BUSES` incoming receiver channels and arbitrates round-robin among pending kill, send and stream requests. Send and stream words are queued in a parametrised FIFO and presented to the core pipeline through one valid/ready port. Kills bypass the queue as a one-cycle pulse. It replaces the per-bus ack wiring previously tied directly into the core.

## Interface
- `WORD_MAG`, 5: log2 of word width; `WORD_WIDTH = 1 << WORD_MAG`.
- `TOTAL_BUSES`, 4: number of receiver buses, ≥1.
- `FIFO_DEPTH_MAG`, 2: log2 of FIFO depth; `DEPTH = 1 << FIFO_DEPTH_MAG`.
- `BUS_W` (local): `max(1, $clog2(TOTAL_BUSES))`.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `receiver_enables`  in  TOTAL_BUSES  bus is enabled/connected.
- `receiver_kills`  in  TOTAL_BUSES  kill request.
- `receiver_sends`  in  TOTAL_BUSES  send request.
- `receiver_streams`  in  TOTAL_BUSES  stream request.
- `receiver_datas`  in  TOTAL_BUSES×WORD_WIDTH  per-bus data word.
- `receiver_kill_acks`  out  TOTAL_BUSES  kill accepted.
- `receiver_send_acks`  out  TOTAL_BUSES  send accepted.
- `receiver_stream_acks`  out  TOTAL_BUSES  stream accepted.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  core consumes head.
- `out_stream`  out  1  head is a stream word (0 = send).
- `out_bus`  out  BUS_W  source bus of head.
- `out_data`  out  WORD_WIDTH  head data.
- `kill_valid`  out  1  one-cycle kill pulse, registered.
- `kill_bus`  out  BUS_W  source bus of kill.
- `fifo_count`  out  FIFO_DEPTH_MAG+1  occupancy.

## Operation
- Kill request on bus i: `enables[i] & kills[i]`.
- Data request on bus i: `enables[i] & (sends[i] | streams[i]) & ~kills[i]`. A bus with a kill asserted offers no data that cycle.
- Per bus, send has priority over stream. The losing signal gets no ack.
- Kill arbitration:
  - Every cycle with any kill request, grant exactly one bus round-robin from `kill_ptr`.
  - Assert `receiver_kill_acks[g]` combinationally in that cycle.
  - Next edge: `kill_valid` ← 1, `kill_bus` ← g, `kill_ptr` ← (g+1) mod TOTAL_BUSES.
  - Never blocked by FIFO state.
- Data arbitration:
  - `can_push = (fifo_count != DEPTH) | (out_valid & out_ready)`.
  - If `can_push` and any data request, grant one bus g round-robin from `data_ptr`.
  - Assert the matching send or stream ack for g combinationally.
  - At the edge: write {stream, g, `receiver_datas[g]`} at the tail; `data_ptr` ← (g+1) mod TOTAL_BUSES.
- Round-robin: search indices ptr, ptr+1, … wrapping mod TOTAL_BUSES. First requester wins. A pointer moves only on a grant.
- FIFO:
  - First-word-fall-through; `out_*` reflect the head.
  - Pop when `out_valid & out_ready`.
  - Push and pop in the same cycle leave the count unchanged, including at full (DEPTH) and at count 1.
  - Pop when empty is ignored.
  - Read/write pointers wrap mod DEPTH.
- At most one kill ack and one data ack per cycle. They may be on different buses. Each ack is a single-cycle acceptance of one request.
- A sender holding its request receives further acks on later grants, one word per ack.

## Timing
- Ack latency: 0 cycles, combinational from request/`out_ready`/state. Acks must not depend combinationally on `out_data`.
- Data latency: pushed word appears at `out_*` the cycle after its ack (empty FIFO); `out_valid` rises the same cycle.
- Kill latency: `kill_valid` high for exactly the cycle after the ack.
- Reset values: `out_valid`=0, `fifo_count`=0, `kill_valid`=0, `kill_bus`=0, both pointers 0. During reset all acks=0, regardless of inputs.
- Reset mid-operation: FIFO contents are discarded at the next edge and no grant is made in the reset cycle.
- `out_data`/`out_bus`/`out_stream` are don't-care while `out_valid`=0.

## Test plan
- Reset with all four buses sending → all acks 0 during reset. First cycle after reset: send ack on bus 0 only; next cycle `out_valid`=1, `out_bus`=0, `out_data`=bus 0 word.
- Buses 1 and 3 holding sends, `out_ready`=1, 6 cycles → acks alternate 1,3,1,3,1,3; `out_bus` sequence matches one cycle later.
- `out_ready`=0, DEPTH=4, bus 2 streaming words 0xA0…0xA5 → 4 acks, `fifo_count`=4, then no ack. Raise `out_ready` → `out_data` 0xA0,0xA1,…; with stream held, the push+pop at full keeps count at 4.
- Bus 0 kill + send, bus 1 send, same cycle → kill ack on 0, send ack on 1, no send ack on 0. Next cycle `kill_valid`=1, `kill_bus`=0, `out_bus`=1.
- Kills on buses 0,1,2 held with FIFO full → kill acks rotate 0,1,2 every cycle. `kill_valid` stays high 3 cycles with `kill_bus` 0,1,2.
- Bus 3 with `enables`=0 asserting send, stream and kill → no acks ever, `out_valid` stays 0, `kill_valid` stays 0.

Source files
------------

// File: rtl/uarc_receiver_arbiter.sv
// Receiver-side front end for the UARC bus set: round-robin kill and data
// arbitration across TOTAL_BUSES channels, a first-word-fall-through queue for
// send/stream words, and a registered one-cycle kill pulse.
module uarc_receiver_arbiter #(
  parameter int WORD_MAG       = 5,
  parameter int TOTAL_BUSES    = 4,
  parameter int FIFO_DEPTH_MAG = 2,
  localparam int WORD_WIDTH    = 1 << WORD_MAG,
  localparam int DEPTH         = 1 << FIFO_DEPTH_MAG,
  localparam int BUS_W         = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [TOTAL_BUSES-1:0]            receiver_enables,
  input  logic [TOTAL_BUSES-1:0]            receiver_kills,
  input  logic [TOTAL_BUSES-1:0]            receiver_sends,
  input  logic [TOTAL_BUSES-1:0]            receiver_streams,
  input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_datas,
  output logic [TOTAL_BUSES-1:0]            receiver_kill_acks,
  output logic [TOTAL_BUSES-1:0]            receiver_send_acks,
  output logic [TOTAL_BUSES-1:0]            receiver_stream_acks,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_stream,
  output logic [BUS_W-1:0]                  out_bus,
  output logic [WORD_WIDTH-1:0]             out_data,
  output logic                              kill_valid,
  output logic [BUS_W-1:0]                  kill_bus,
  output logic [FIFO_DEPTH_MAG:0]           fifo_count
);

  localparam logic [FIFO_DEPTH_MAG:0] DEPTH_CNT = (FIFO_DEPTH_MAG + 1)'(DEPTH);

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [BUS_W:0] rr_pick(input logic [TOTAL_BUSES-1:0] req,
                                             input logic [BUS_W-1:0] ptr);
    logic                   found;
    logic [BUS_W-1:0]       idx;
    logic [TOTAL_BUSES-1:0] req_sh;
    int                     cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < TOTAL_BUSES; k++) begin
      cand   = (int'(ptr) + k) % TOTAL_BUSES;
      req_sh = req >> cand;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        idx   = BUS_W'(cand);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [BUS_W-1:0] ptr_after(input logic [BUS_W-1:0] g);
    return BUS_W'((int'(g) + 1) % TOTAL_BUSES);
  endfunction

  logic [BUS_W-1:0]          kill_ptr_q, kill_ptr_d;
  logic [BUS_W-1:0]          data_ptr_q, data_ptr_d;
  logic                      kill_valid_q, kill_valid_d;
  logic [BUS_W-1:0]          kill_bus_q, kill_bus_d;
  logic [FIFO_DEPTH_MAG-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_MAG-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_MAG:0]   count_q, count_d;

  logic [WORD_WIDTH-1:0]     mem_data_q   [DEPTH];
  logic [BUS_W-1:0]          mem_bus_q    [DEPTH];
  logic                      mem_stream_q [DEPTH];

  logic [TOTAL_BUSES-1:0]    kill_req, data_req;
  logic [BUS_W:0]            kill_pick, data_pick;
  logic                      kill_gnt, data_gnt, can_push, pop;
  logic [BUS_W-1:0]          kill_idx, data_idx;
  logic                      push_stream;
  logic [WORD_WIDTH-1:0]     push_data;
  logic [TOTAL_BUSES-1:0]    sends_sh;

  // Request qualification and both round-robin grants; reset suppresses grants.
  always_comb begin
    kill_req  = receiver_enables & receiver_kills;
    data_req  = receiver_enables & (receiver_sends | receiver_streams) & ~receiver_kills;
    pop       = out_valid & out_ready;
    can_push  = (count_q != DEPTH_CNT) | pop;
    kill_pick = rr_pick(kill_req, kill_ptr_q);
    data_pick = rr_pick(data_req, data_ptr_q);
    kill_gnt  = kill_pick[BUS_W] & ~reset;
    kill_idx  = kill_pick[BUS_W-1:0];
    data_gnt  = data_pick[BUS_W] & can_push & ~reset;
    data_idx  = data_pick[BUS_W-1:0];
    // Send wins over stream on the same bus; the pushed word is tagged accordingly.
    sends_sh    = receiver_sends >> data_idx;
    push_stream = ~sends_sh[0];
    push_data   = WORD_WIDTH'(receiver_datas >> (int'(data_idx) * WORD_WIDTH));
  end

  // Combinational acks, one-hot on the granted bus.
  always_comb begin
    receiver_kill_acks   = '0;
    receiver_send_acks   = '0;
    receiver_stream_acks = '0;
    if (kill_gnt) receiver_kill_acks = TOTAL_BUSES'(1) << kill_idx;
    if (data_gnt) begin
      if (push_stream) receiver_stream_acks = TOTAL_BUSES'(1) << data_idx;
      else             receiver_send_acks   = TOTAL_BUSES'(1) << data_idx;
    end
  end

  // Next-state for pointers, kill pulse and queue occupancy.
  always_comb begin
    kill_ptr_d   = kill_gnt ? ptr_after(kill_idx) : kill_ptr_q;
    data_ptr_d   = data_gnt ? ptr_after(data_idx) : data_ptr_q;
    kill_valid_d = kill_gnt;
    kill_bus_d   = kill_gnt ? kill_idx : kill_bus_q;
    wr_ptr_d     = data_gnt ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({data_gnt, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards queued words by clearing pointers and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      kill_ptr_q   <= '0;
      data_ptr_q   <= '0;
      kill_valid_q <= 1'b0;
      kill_bus_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      kill_ptr_q   <= kill_ptr_d;
      data_ptr_q   <= data_ptr_d;
      kill_valid_q <= kill_valid_d;
      kill_bus_q   <= kill_bus_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Queue storage is written at the tail on a data grant; no reset needed.
  always_ff @(posedge clk) begin
    if (data_gnt) begin
      mem_data_q[wr_ptr_q]   <= push_data;
      mem_bus_q[wr_ptr_q]    <= data_idx;
      mem_stream_q[wr_ptr_q] <= push_stream;
    end
  end

  // Head of the queue falls through to the output port.
  always_comb begin
    out_valid  = (count_q != '0);
    out_data   = mem_data_q[rd_ptr_q];
    out_bus    = mem_bus_q[rd_ptr_q];
    out_stream = mem_stream_q[rd_ptr_q];
    kill_valid = kill_valid_q;
    kill_bus   = kill_bus_q;
    fifo_count = count_q;
  end

endmodule

// File: tb/tb_uarc_receiver_arbiter.sv
// Directed bench for uarc_receiver_arbiter with default parameters
// (4 buses, 32-bit words, depth-4 queue).
module tb_uarc_receiver_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   en, kills, sends, streams;
  logic [31:0]  dw [4];
  logic [127:0] datas;
  logic [3:0]   kill_acks, send_acks, stream_acks;
  logic         out_valid, out_ready, out_stream, kill_valid;
  logic [1:0]   out_bus, kill_bus;
  logic [31:0]  out_data;
  logic [2:0]   fifo_count;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  int exp_bus;
  int prev_bus;

  assign datas = {dw[3], dw[2], dw[1], dw[0]};

  always #5 clk = ~clk;

  uarc_receiver_arbiter dut (
    .clk                  (clk),
    .reset                (reset),
    .receiver_enables     (en),
    .receiver_kills       (kills),
    .receiver_sends       (sends),
    .receiver_streams     (streams),
    .receiver_datas       (datas),
    .receiver_kill_acks   (kill_acks),
    .receiver_send_acks   (send_acks),
    .receiver_stream_acks (stream_acks),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_stream           (out_stream),
    .out_bus              (out_bus),
    .out_data             (out_data),
    .kill_valid           (kill_valid),
    .kill_bus             (kill_bus),
    .fifo_count           (fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 4'hF; kills = 4'h0; sends = 4'hF; streams = 4'h0; out_ready = 1'b0;
    dw[0] = 32'h100; dw[1] = 32'h101; dw[2] = 32'h102; dw[3] = 32'h103;

    // Reset with every bus sending
    step(); #1;
    chk("rst_send_acks",   32'(send_acks),   32'h0);
    chk("rst_stream_acks", 32'(stream_acks), 32'h0);
    chk("rst_kill_acks",   32'(kill_acks),   32'h0);
    step(); #1;
    chk("rst_send_acks2",  32'(send_acks),   32'h0);
    chk("rst_out_valid",   32'(out_valid),   32'h0);
    chk("rst_fifo_count",  32'(fifo_count),  32'h0);
    chk("rst_kill_valid",  32'(kill_valid),  32'h0);
    chk("rst_kill_bus",    32'(kill_bus),    32'h0);

    step(); reset = 1'b0; #1;
    chk("first_send_ack",   32'(send_acks),   32'h1);
    chk("first_stream_ack", 32'(stream_acks), 32'h0);
    step(); sends = 4'h0; out_ready = 1'b1; #1;
    chk("first_out_valid", 32'(out_valid),  32'h1);
    chk("first_out_bus",   32'(out_bus),    32'h0);
    chk("first_out_data",  out_data,        32'h100);
    chk("first_count",     32'(fifo_count), 32'h1);

    // Buses 1 and 3 alternate while the queue streams through
    dw[1] = 32'h11; dw[3] = 32'h33;
    prev_bus = 0;
    for (int k = 0; k < 6; k++) begin
      step(); sends = 4'b1010; #1;
      exp_bus = (k % 2 == 1) ? 3 : 1;
      chk("rr_send_ack", 32'(send_acks), 32'(1 << exp_bus));
      if (k > 0) begin
        chk("rr_out_bus",  32'(out_bus), 32'(prev_bus));
        chk("rr_out_data", out_data, (prev_bus == 1) ? 32'h11 : 32'h33);
        chk("rr_count",    32'(fifo_count), 32'h1);
      end else begin
        chk("rr_empty_before", 32'(out_valid), 32'h0);
      end
      prev_bus = exp_bus;
    end
    step(); sends = 4'h0; #1;
    chk("rr_last_bus",  32'(out_bus),   32'h3);
    chk("rr_last_data", out_data,       32'h33);
    step(); #1;
    chk("rr_drained",   32'(out_valid), 32'h0);

    // Bus 2 streams into a blocked queue until full
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step(); streams = 4'b0100; dw[2] = 32'hA0 + 32'(j); #1;
      chk("fill_stream_ack", 32'(stream_acks), 32'h4);
      chk("fill_count",      32'(fifo_count),  32'(j));
    end
    step(); dw[2] = 32'hA4; #1;
    chk("full_no_ack",     32'(stream_acks), 32'h0);
    chk("full_count",      32'(fifo_count),  32'h4);
    chk("full_out_stream", 32'(out_stream),  32'h1);
    chk("full_head",       out_data,         32'hA0);
    step(); out_ready = 1'b1; #1;
    chk("full_pushpop_ack", 32'(stream_acks), 32'h4);
    chk("full_pushpop_cnt", 32'(fifo_count),  32'h4);
    chk("full_pushpop_dat", out_data,         32'hA0);
    step(); dw[2] = 32'hA5; #1;
    chk("full_pushpop_ack2", 32'(stream_acks), 32'h4);
    chk("full_pushpop_cnt2", 32'(fifo_count),  32'h4);
    chk("full_pushpop_dat2", out_data,         32'hA1);
    step(); streams = 4'h0; #1;
    chk("drain_no_ack", 32'(stream_acks), 32'h0);
    chk("drain_cnt0",   32'(fifo_count),  32'h4);
    chk("drain_dat0",   out_data,         32'hA2);
    for (int m = 0; m < 3; m++) begin
      step(); #1;
      chk("drain_dat", out_data,        32'hA3 + 32'(m));
      chk("drain_cnt", 32'(fifo_count), 32'(3 - m));
    end
    step(); #1;
    chk("drain_empty", 32'(out_valid), 32'h0);

    // Kill and send on bus 0 plus send on bus 1 in one cycle
    step(); kills = 4'b0001; sends = 4'b0011; dw[0] = 32'hC0; dw[1] = 32'hC1; #1;
    chk("ks_kill_ack", 32'(kill_acks),   32'h1);
    chk("ks_send_ack", 32'(send_acks),   32'h2);
    chk("ks_strm_ack", 32'(stream_acks), 32'h0);
    step(); kills = 4'h0; sends = 4'h0; #1;
    chk("ks_kill_valid", 32'(kill_valid), 32'h1);
    chk("ks_kill_bus",   32'(kill_bus),   32'h0);
    chk("ks_out_bus",    32'(out_bus),    32'h1);
    chk("ks_out_data",   out_data,        32'hC1);
    step(); #1;
    chk("ks_kill_pulse_end", 32'(kill_valid), 32'h0);
    chk("ks_out_empty",      32'(out_valid),  32'h0);

    // Reset in the middle of operation discards queued words
    out_ready = 1'b0;
    step(); sends = 4'b1000; dw[3] = 32'hD0; #1;
    chk("mid_ack0", 32'(send_acks), 32'h8);
    step(); #1;
    chk("mid_ack1", 32'(send_acks), 32'h8);
    step(); reset = 1'b1; kills = 4'b0111; #1;
    chk("mid_rst_send_ack", 32'(send_acks),  32'h0);
    chk("mid_rst_kill_ack", 32'(kill_acks),  32'h0);
    chk("mid_rst_count",    32'(fifo_count), 32'h2);
    step(); reset = 1'b0; kills = 4'h0; #1;
    chk("post_rst_count", 32'(fifo_count), 32'h0);
    chk("post_rst_valid", 32'(out_valid),  32'h0);
    chk("post_rst_ack",   32'(send_acks),  32'h8);
    for (int r = 1; r < 4; r++) begin
      step(); #1;
      chk("refill_ack", 32'(send_acks),  32'h8);
      chk("refill_cnt", 32'(fifo_count), 32'(r));
    end

    // Kills rotate while the queue is full
    step(); kills = 4'b0111; #1;
    chk("kfull_count",   32'(fifo_count), 32'h4);
    chk("kfull_no_send", 32'(send_acks),  32'h0);
    chk("krot_ack0",     32'(kill_acks),  32'h1);
    step(); #1;
    chk("krot_ack1", 32'(kill_acks),  32'h2);
    chk("krot_kv1",  32'(kill_valid), 32'h1);
    chk("krot_kb1",  32'(kill_bus),   32'h0);
    step(); #1;
    chk("krot_ack2", 32'(kill_acks),  32'h4);
    chk("krot_kv2",  32'(kill_valid), 32'h1);
    chk("krot_kb2",  32'(kill_bus),   32'h1);
    step(); kills = 4'h0; sends = 4'h0; #1;
    chk("krot_ack_none", 32'(kill_acks),  32'h0);
    chk("krot_kv3",      32'(kill_valid), 32'h1);
    chk("krot_kb3",      32'(kill_bus),   32'h2);
    step(); out_ready = 1'b1; #1;
    chk("krot_kv_end", 32'(kill_valid), 32'h0);
    repeat (4) step();
    #1;
    chk("kfull_drained", 32'(fifo_count), 32'h0);

    // Disabled bus 3 requesting everything
    en = 4'b0111; sends = 4'b1000; streams = 4'b1000; kills = 4'b1000;
    for (int d = 0; d < 3; d++) begin
      step(); #1;
      chk("dis_send_ack", 32'(send_acks),   32'h0);
      chk("dis_strm_ack", 32'(stream_acks), 32'h0);
      chk("dis_kill_ack", 32'(kill_acks),   32'h0);
    end
    step(); #1;
    chk("dis_out_valid",  32'(out_valid),  32'h0);
    chk("dis_kill_valid", 32'(kill_valid), 32'h0);

    // Send beats stream on the same bus
    step(); en = 4'hF; kills = 4'h0; sends = 4'b0001; streams = 4'b0001; dw[0] = 32'hE0; #1;
    chk("prio_send_ack", 32'(send_acks),   32'h1);
    chk("prio_strm_ack", 32'(stream_acks), 32'h0);
    step(); sends = 4'h0; streams = 4'h0; #1;
    chk("prio_out_valid",  32'(out_valid),  32'h1);
    chk("prio_out_stream", 32'(out_stream), 32'h0);
    chk("prio_out_data",   out_data,        32'hE0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
